// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock mode/edit controller.
// State encoding, time field limits and the one-hot edit-field LED codes.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    ST_CLOCK  = 3'd0,
    ST_T_HOUR = 3'd1,
    ST_T_MIN  = 3'd2,
    ST_A_HOUR = 3'd3,
    ST_A_MIN  = 3'd4,
    ST_RING   = 3'd5
  } state_e;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  // LED order is {T_HOUR, T_MIN, A_HOUR, A_MIN}
  localparam logic [3:0] FIELD_NONE   = 4'b0000;
  localparam logic [3:0] FIELD_T_HOUR = 4'b1000;
  localparam logic [3:0] FIELD_T_MIN  = 4'b0100;
  localparam logic [3:0] FIELD_A_HOUR = 4'b0010;
  localparam logic [3:0] FIELD_A_MIN  = 4'b0001;

  function automatic logic [3:0] field_of(input state_e s);
    case (s)
      ST_T_HOUR: field_of = FIELD_T_HOUR;
      ST_T_MIN:  field_of = FIELD_T_MIN;
      ST_A_HOUR: field_of = FIELD_A_HOUR;
      ST_A_MIN:  field_of = FIELD_A_MIN;
      default:   field_of = FIELD_NONE;
    endcase
  endfunction

  function automatic logic is_edit(input state_e s);
    is_edit = (s == ST_T_HOUR) || (s == ST_T_MIN) ||
              (s == ST_A_HOUR) || (s == ST_A_MIN);
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: hour/minute setting with independent wrap-around stepping
// and the combinational match against the current time.
module alarm_slot
  import alarm_clock_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_hr_i,
  input  logic       dec_hr_i,
  input  logic       inc_min_i,
  input  logic       dec_min_i,
  input  logic       arm_i,
  input  logic [4:0] cur_hour_i,
  input  logic [5:0] cur_min_i,
  input  logic [5:0] cur_sec_i,
  output logic [4:0] hour_o,
  output logic [5:0] min_o,
  output logic       match_o
);

  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;

  // Minute wrap deliberately does not carry into the hour.
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    if (inc_hr_i)       hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
    else if (dec_hr_i)  hour_d = (hour_q == 5'd0) ? HOUR_MAX : hour_q - 5'd1;
    if (inc_min_i)      min_d  = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
    else if (dec_min_i) min_d  = (min_q == 6'd0) ? MIN_MAX : min_q - 6'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hour_q <= 5'd0;
      min_q  <= 6'd0;
    end else begin
      hour_q <= hour_d;
      min_q  <= min_d;
    end
  end

  assign hour_o  = hour_q;
  assign min_o   = min_q;
  assign match_o = arm_i && (cur_hour_i == hour_q) && (cur_min_i == min_q) &&
                   (cur_sec_i == 6'd0);

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Mode/edit controller for the multi-alarm clock: edit ring, time-adjust
// steering, alarm/snooze triggering, ring and edit timeouts.
//
//   state    | meaning
//   ST_CLOCK | normal timekeeping, watching for a match edge
//   ST_T_HOUR| editing current-time hour (time counter stopped)
//   ST_T_MIN | editing current-time minute (time counter stopped)
//   ST_A_HOUR| editing hour of alarm slot sel_idx
//   ST_A_MIN | editing minute of alarm slot sel_idx
//   ST_RING  | alarm or snooze ringing
module multi_alarm_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int NUM_ALARMS     = 2,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int EDIT_TIMEOUT_S = 30
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick_1hz_i,
  input  logic                  btn_c_i,
  input  logic                  btn_l_i,
  input  logic                  btn_r_i,
  input  logic                  btn_u_i,
  input  logic                  btn_d_i,
  input  logic [4:0]            cur_hour_i,
  input  logic [5:0]            cur_min_i,
  input  logic [5:0]            cur_sec_i,
  input  logic [NUM_ALARMS-1:0] alarm_on_i,
  output logic                  run_en_o,
  output logic                  time_adj_hr_o,
  output logic                  time_adj_min_o,
  output logic                  time_up_o,
  output logic                  disp_alarm_o,
  output logic [4:0]            disp_hour_o,
  output logic [5:0]            disp_min_o,
  output logic [1:0]            sel_idx_o,
  output logic [3:0]            led_field_o,
  output logic                  ring_o,
  output logic                  ring_blink_o,
  output logic [1:0]            ring_idx_o
);

  localparam logic [7:0] EDIT_LOAD = 8'(EDIT_TIMEOUT_S);
  localparam logic [7:0] RING_LOAD = 8'(RING_TIMEOUT_S);
  localparam logic [1:0] SEL_LAST  = 2'(NUM_ALARMS - 1);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ring_idx_q, ring_idx_d;
  logic       adj_hr_q, adj_hr_d, adj_min_q, adj_min_d, up_q, up_d;
  logic       blink_q, blink_d;
  logic       match_prev_q;
  logic       snz_act_q, snz_act_d;
  logic [4:0] snz_hr_q, snz_hr_d;
  logic [5:0] snz_min_q, snz_min_d;
  logic [7:0] edit_cnt_q, edit_cnt_d, ring_cnt_q, ring_cnt_d;

  logic       hr_up, hr_dn, min_up, min_dn;
  logic [NUM_ALARMS-1:0] slot_match;
  logic [4:0] slot_hr  [NUM_ALARMS];
  logic [5:0] slot_min [NUM_ALARMS];

  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_slot
    alarm_slot u_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_hr_i   (hr_up  && (sel_q == 2'(k))),
      .dec_hr_i   (hr_dn  && (sel_q == 2'(k))),
      .inc_min_i  (min_up && (sel_q == 2'(k))),
      .dec_min_i  (min_dn && (sel_q == 2'(k))),
      .arm_i      (alarm_on_i[k]),
      .cur_hour_i (cur_hour_i),
      .cur_min_i  (cur_min_i),
      .cur_sec_i  (cur_sec_i),
      .hour_o     (slot_hr[k]),
      .min_o      (slot_min[k]),
      .match_o    (slot_match[k])
    );
  end

  logic       any_btn, snz_match, any_match, match_edge, edit_tc, ring_tc;
  logic [1:0] hit_idx;
  logic [6:0] min_sum;

  assign any_btn    = btn_c_i | btn_l_i | btn_r_i | btn_u_i | btn_d_i;
  assign snz_match  = snz_act_q && (cur_hour_i == snz_hr_q) &&
                      (cur_min_i == snz_min_q) && (cur_sec_i == 6'd0);
  assign any_match  = (|slot_match) || snz_match;
  assign match_edge = any_match && !match_prev_q;
  assign edit_tc    = tick_1hz_i && (edit_cnt_q == 8'd1);
  assign ring_tc    = tick_1hz_i && (ring_cnt_q == 8'd1);
  assign min_sum    = {1'b0, cur_min_i} + 7'(SNOOZE_MIN);

  // Snooze ranks below every slot; with four slots it aliases to index 0.
  always_comb begin
    hit_idx = 2'(NUM_ALARMS);
    for (int k = NUM_ALARMS - 1; k >= 0; k--)
      if (slot_match[k]) hit_idx = 2'(k);
  end

  always_comb begin
    disp_hour_o = 5'd0;
    disp_min_o  = 6'd0;
    for (int k = 0; k < NUM_ALARMS; k++)
      if (sel_q == 2'(k)) begin
        disp_hour_o = slot_hr[k];
        disp_min_o  = slot_min[k];
      end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ring_idx_d = ring_idx_q;
    snz_act_d  = snz_act_q;
    snz_hr_d   = snz_hr_q;
    snz_min_d  = snz_min_q;
    adj_hr_d   = 1'b0;
    adj_min_d  = 1'b0;
    up_d       = 1'b0;
    hr_up      = 1'b0;
    hr_dn      = 1'b0;
    min_up     = 1'b0;
    min_dn     = 1'b0;
    case (state_q)
      ST_CLOCK: begin
        if (match_edge) begin
          state_d    = ST_RING;
          ring_idx_d = hit_idx;
          if (snz_match) snz_act_d = 1'b0;
        end else if (btn_c_i) begin
          state_d = ST_T_HOUR;
        end
      end
      ST_T_HOUR: begin
        if (btn_c_i)                 state_d = ST_CLOCK;
        else if (btn_r_i)            state_d = ST_T_MIN;
        else if (btn_l_i) begin
          state_d = ST_A_MIN;
          sel_d   = SEL_LAST;
        end else if (btn_u_i || btn_d_i) begin
          adj_hr_d = 1'b1;
          up_d     = btn_u_i;
        end else if (edit_tc)        state_d = ST_CLOCK;
      end
      ST_T_MIN: begin
        if (btn_c_i)                 state_d = ST_CLOCK;
        else if (btn_r_i) begin
          state_d = ST_A_HOUR;
          sel_d   = 2'd0;
        end else if (btn_l_i)        state_d = ST_T_HOUR;
        else if (btn_u_i || btn_d_i) begin
          adj_min_d = 1'b1;
          up_d      = btn_u_i;
        end else if (edit_tc)        state_d = ST_CLOCK;
      end
      ST_A_HOUR: begin
        if (btn_c_i)                 state_d = ST_CLOCK;
        else if (btn_r_i)            state_d = ST_A_MIN;
        else if (btn_l_i) begin
          if (sel_q == 2'd0) state_d = ST_T_MIN;
          else begin
            state_d = ST_A_MIN;
            sel_d   = sel_q - 2'd1;
          end
        end else if (btn_u_i)        hr_up = 1'b1;
        else if (btn_d_i)            hr_dn = 1'b1;
        else if (edit_tc)            state_d = ST_CLOCK;
      end
      ST_A_MIN: begin
        if (btn_c_i)                 state_d = ST_CLOCK;
        else if (btn_r_i) begin
          if (sel_q == SEL_LAST) state_d = ST_T_HOUR;
          else begin
            state_d = ST_A_HOUR;
            sel_d   = sel_q + 2'd1;
          end
        end else if (btn_l_i)        state_d = ST_A_HOUR;
        else if (btn_u_i)            min_up = 1'b1;
        else if (btn_d_i)            min_dn = 1'b1;
        else if (edit_tc)            state_d = ST_CLOCK;
      end
      ST_RING: begin
        if (btn_c_i) begin
          state_d   = ST_CLOCK;
          snz_act_d = 1'b0;
        end else if (any_btn) begin
          state_d   = ST_CLOCK;
          snz_act_d = 1'b1;
          if (min_sum >= 7'd60) begin
            snz_min_d = 6'(min_sum - 7'd60);
            snz_hr_d  = (cur_hour_i == HOUR_MAX) ? 5'd0 : cur_hour_i + 5'd1;
          end else begin
            snz_min_d = 6'(min_sum);
            snz_hr_d  = cur_hour_i;
          end
        end else if (ring_tc) begin
          state_d = ST_CLOCK;
        end
      end
      default: state_d = ST_CLOCK;
    endcase
  end

  always_comb begin
    edit_cnt_d = edit_cnt_q;
    ring_cnt_d = ring_cnt_q;
    if (!is_edit(state_q) || any_btn)           edit_cnt_d = EDIT_LOAD;
    else if (tick_1hz_i && edit_cnt_q != 8'd0)  edit_cnt_d = edit_cnt_q - 8'd1;
    if (state_q != ST_RING)                     ring_cnt_d = RING_LOAD;
    else if (tick_1hz_i && ring_cnt_q != 8'd0)  ring_cnt_d = ring_cnt_q - 8'd1;
    blink_d = (state_q == ST_RING && state_d == ST_RING) ? (blink_q ^ tick_1hz_i) : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_CLOCK;
      sel_q        <= 2'd0;
      ring_idx_q   <= 2'd0;
      adj_hr_q     <= 1'b0;
      adj_min_q    <= 1'b0;
      up_q         <= 1'b0;
      blink_q      <= 1'b0;
      match_prev_q <= 1'b0;
      snz_act_q    <= 1'b0;
      snz_hr_q     <= 5'd0;
      snz_min_q    <= 6'd0;
      edit_cnt_q   <= EDIT_LOAD;
      ring_cnt_q   <= RING_LOAD;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ring_idx_q   <= ring_idx_d;
      adj_hr_q     <= adj_hr_d;
      adj_min_q    <= adj_min_d;
      up_q         <= up_d;
      blink_q      <= blink_d;
      match_prev_q <= any_match;
      snz_act_q    <= snz_act_d;
      snz_hr_q     <= snz_hr_d;
      snz_min_q    <= snz_min_d;
      edit_cnt_q   <= edit_cnt_d;
      ring_cnt_q   <= ring_cnt_d;
    end
  end

  assign run_en_o       = (state_q != ST_T_HOUR) && (state_q != ST_T_MIN);
  assign time_adj_hr_o  = adj_hr_q;
  assign time_adj_min_o = adj_min_q;
  assign time_up_o      = up_q;
  assign disp_alarm_o   = (state_q == ST_A_HOUR) || (state_q == ST_A_MIN);
  assign sel_idx_o      = sel_q;
  assign led_field_o    = field_of(state_q);
  assign ring_o         = (state_q == ST_RING);
  assign ring_blink_o   = blink_q;
  assign ring_idx_o     = ring_idx_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl: edit ring, alarm stepping, snooze,
// timeouts, priority and reset, with hand-computed expectations.
module tb_multi_alarm_ctrl;

  localparam int NA = 2;
  localparam logic [4:0] B_C = 5'b10000, B_L = 5'b01000, B_R = 5'b00100,
                         B_U = 5'b00010, B_D = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, tick, btn_c, btn_l, btn_r, btn_u, btn_d;
  logic [4:0]    cur_hour;
  logic [5:0]    cur_min, cur_sec;
  logic [NA-1:0] alarm_on;
  logic          run_en, adj_hr, adj_min, time_up, disp_alarm, ring, ring_blink;
  logic [4:0]    disp_hour;
  logic [5:0]    disp_min;
  logic [1:0]    sel_idx, ring_idx;
  logic [3:0]    led_field;

  int n_total = 0;
  int n_bad   = 0;

  multi_alarm_ctrl #(.NUM_ALARMS(NA), .SNOOZE_MIN(5), .RING_TIMEOUT_S(60),
                     .EDIT_TIMEOUT_S(30)) dut (
    .clk_i(clk), .rst_i(rst), .tick_1hz_i(tick),
    .btn_c_i(btn_c), .btn_l_i(btn_l), .btn_r_i(btn_r), .btn_u_i(btn_u), .btn_d_i(btn_d),
    .cur_hour_i(cur_hour), .cur_min_i(cur_min), .cur_sec_i(cur_sec),
    .alarm_on_i(alarm_on),
    .run_en_o(run_en), .time_adj_hr_o(adj_hr), .time_adj_min_o(adj_min),
    .time_up_o(time_up), .disp_alarm_o(disp_alarm), .disp_hour_o(disp_hour),
    .disp_min_o(disp_min), .sel_idx_o(sel_idx), .led_field_o(led_field),
    .ring_o(ring), .ring_blink_o(ring_blink), .ring_idx_o(ring_idx)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] m);
    {btn_c, btn_l, btn_r, btn_u, btn_d} = m;
    step();
    {btn_c, btn_l, btn_r, btn_u, btn_d} = 5'b0;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hour = 5'(h);
    cur_min  = 6'(m);
    cur_sec  = 6'(s);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; alarm_on = '0;
    {btn_c, btn_l, btn_r, btn_u, btn_d} = 5'b0;
    set_time(12, 0, 5);
    step(); step();
    chk_val("rst_ring",   32'(ring), 0);
    chk_val("rst_run_en", 32'(run_en), 1);
    chk_val("rst_led",    32'(led_field), 0);
    chk_val("rst_sel",    32'(sel_idx), 0);
    chk_val("rst_disp_a", 32'(disp_alarm), 0);
    chk_val("rst_adj",    32'({adj_hr, adj_min, time_up, ring_blink}), 0);
    chk_val("rst_ridx",   32'(ring_idx), 0);
    rst = 1'b0;
    step();

    press(B_C);
    chk_val("thour_led", 32'(led_field), 8);
    chk_val("thour_run", 32'(run_en), 0);
    press(B_U);
    chk_val("adj_hr_up",  32'(adj_hr), 1);
    chk_val("adj_up_dir", 32'(time_up), 1);
    chk_val("adj_run",    32'(run_en), 0);
    chk_val("adj_min_no", 32'(adj_min), 0);
    step();
    chk_val("adj_hr_1cyc", 32'(adj_hr), 0);
    press(B_D);
    chk_val("adj_hr_dn",  32'({adj_hr, time_up}), 2);
    press(B_R);
    chk_val("tmin_led",   32'(led_field), 4);
    press(B_U);
    chk_val("adj_min_up", 32'({adj_min, time_up}), 3);

    press(B_R);
    chk_val("a0h_led",    32'(led_field), 2);
    chk_val("a0h_sel",    32'(sel_idx), 0);
    chk_val("a0h_disp",   32'(disp_alarm), 1);
    press(B_D);
    chk_val("a0h_wrap_dn", 32'(disp_hour), 23);
    press(B_U);
    chk_val("a0h_wrap_up", 32'(disp_hour), 0);
    repeat (7) press(B_U);
    chk_val("a0h_7", 32'(disp_hour), 7);
    press(B_R);
    chk_val("a0m_led", 32'(led_field), 1);
    repeat (30) press(B_U);
    chk_val("a0m_30", 32'(disp_min), 30);

    press(B_R);
    chk_val("a1h_sel", 32'({sel_idx, led_field}), 32'({2'd1, 4'd2}));
    chk_val("a1h_hr0", 32'(disp_hour), 0);
    press(B_D);
    chk_val("a1h_23", 32'(disp_hour), 23);
    press(B_R);
    press(B_D);
    chk_val("a1m_59", 32'(disp_min), 59);
    press(B_U);
    chk_val("a1m_wrap", 32'(disp_min), 0);
    chk_val("a1m_nocarry", 32'(disp_hour), 23);
    press(B_D); press(B_D);
    chk_val("a1m_58", 32'(disp_min), 58);

    press(B_R);
    chk_val("ring_wrap_r", 32'(led_field), 8);
    press(B_L);
    chk_val("ring_wrap_l", 32'({sel_idx, led_field}), 32'({2'd1, 4'd1}));
    press(B_L);
    press(B_L);
    chk_val("l_to_a0m", 32'({sel_idx, led_field}), 32'({2'd0, 4'd1}));
    chk_val("a0m_disp", 32'(disp_min), 30);
    press(B_C);
    chk_val("back_clock", 32'({led_field, disp_alarm, run_en}), 32'({4'd0, 1'b0, 1'b1}));

    press(B_C | B_R);
    chk_val("prio_c_r", 32'(led_field), 8);
    press(B_R | B_L);
    chk_val("prio_r_l", 32'(led_field), 4);
    repeat (29) tick_once();
    chk_val("edit_29", 32'(led_field), 4);
    tick_once();
    chk_val("edit_to", 32'({led_field, run_en}), 1);

    alarm_on = 2'b11;
    set_time(7, 29, 59); step();
    chk_val("pre_0730", 32'(ring), 0);
    set_time(7, 30, 0); step();
    chk_val("ring_0730", 32'({ring, ring_idx}), 32'({1'b1, 2'd0}));
    chk_val("blink0", 32'(ring_blink), 0);
    tick_once();
    chk_val("blink1", 32'(ring_blink), 1);
    tick_once();
    chk_val("blink2", 32'(ring_blink), 0);

    set_time(7, 30, 10);
    press(B_U);
    chk_val("snooze_exit", 32'({ring, ring_blink}), 0);
    set_time(7, 34, 59); step();
    chk_val("pre_0735", 32'(ring), 0);
    set_time(7, 35, 0); step();
    chk_val("snz_fire", 32'({ring, ring_idx}), 32'({1'b1, 2'd2}));
    press(B_C);
    chk_val("dismiss", 32'(ring), 0);
    set_time(7, 35, 1); step();
    set_time(7, 34, 59); step();
    set_time(7, 35, 0); step();
    chk_val("snz_cleared", 32'(ring), 0);

    set_time(23, 57, 59); step();
    set_time(23, 58, 0); step();
    chk_val("ring_2358", 32'({ring, ring_idx}), 32'({1'b1, 2'd1}));
    set_time(23, 58, 20);
    press(B_D);
    set_time(0, 2, 59); step();
    chk_val("pre_0003", 32'(ring), 0);
    set_time(0, 3, 0); step();
    chk_val("snz_midnt", 32'({ring, ring_idx}), 32'({1'b1, 2'd2}));

    repeat (59) tick_once();
    chk_val("ring_59", 32'(ring), 1);
    tick_once();
    chk_val("ring_to", 32'({ring, ring_blink}), 0);

    set_time(7, 29, 59);
    press(B_C);
    set_time(7, 30, 0); step();
    chk_val("lost_edit", 32'(ring), 0);
    press(B_C);
    step();
    chk_val("lost_clock", 32'({ring, led_field}), 0);

    set_time(7, 30, 1); step();
    set_time(7, 29, 59); step();
    set_time(7, 30, 0);
    press(B_C);
    chk_val("match_beats_c", 32'({ring, led_field, ring_idx}), 32'({1'b1, 4'd0, 2'd0}));
    alarm_on = 2'b00; step();
    chk_val("disarm_ring", 32'(ring), 1);

    rst = 1'b1; step();
    chk_val("rst_mid_ring", 32'({ring, led_field, run_en, ring_idx}), 32'({1'b0, 4'd0, 1'b1, 2'd0}));
    chk_val("rst_alarm", 32'({disp_hour, disp_min, sel_idx}), 0);
    rst = 1'b0; step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
